// File: rtl/ysyx_23060124__icache_assoc_pkg.sv
// Shared types, AXI constants and width helpers for the set-associative icache.
package ysyx_23060124__icache_assoc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StRdata,
    StFlush
  } icache_state_e;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [2:0] AxiSize4B    = 3'b010;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  // Width of an index into n entries; never zero so single-entry arrays still get a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Exact log2 of a power of two; 0 for n == 1 (no address bits consumed).
  function automatic int unsigned log2_exact(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/ysyx_23060124__icache_victim.sv
// Victim way selector for one set: lowest invalid way, else the round-robin pointer.
module ysyx_23060124__icache_victim
  import ysyx_23060124__icache_assoc_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned WayW = idx_width(WAYS)
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [WayW-1:0] rr_i,
  output logic [WayW-1:0] way_o
);

  logic found;

  // Scan upwards so the first invalid way wins; fall back to the pointer when all are valid.
  always_comb begin
    found = 1'b0;
    way_o = rr_i;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        found = 1'b1;
        way_o = WayW'(w);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060124__icache_assoc.sv
// Set-associative instruction cache with an AXI4 burst refill port.
module ysyx_23060124__icache_assoc
  import ysyx_23060124__icache_assoc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           data,
  output logic                  hit,
  input  logic                  fence_i,
  output logic                  bus_err,
  output logic [31:0]           M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [3:0]            M_AXI_ARID,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [3:0]            M_AXI_RID,
  input  logic                  M_AXI_RLAST
);

  localparam int unsigned OffW    = log2_exact(4 * LINE_WORDS);
  localparam int unsigned IdxBits = log2_exact(SETS);
  localparam int unsigned IdxW    = idx_width(SETS);
  localparam int unsigned WayW    = idx_width(WAYS);
  localparam int unsigned WordW   = idx_width(LINE_WORDS);
  localparam int unsigned TagW    = ADDR_WIDTH - OffW - IdxBits;

  // Address fields of the current fetch.
  logic [IdxW-1:0]  set_idx;
  logic [WordW-1:0] word_idx;
  logic [TagW-1:0]  tag_in;

  assign set_idx  = (SETS > 1) ? IdxW'(addr >> OffW) : '0;
  assign word_idx = WordW'(addr >> 2);
  assign tag_in   = TagW'(addr >> (OffW + IdxBits));

  // Storage; contents are meaningless until the matching valid bit is set.
  logic [TagW-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]     data_mem [SETS][WAYS][LINE_WORDS];

  // Control state.
  icache_state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]          line_addr_q, line_addr_d;
  logic [IdxW-1:0]                set_q, set_d;
  logic [WayW-1:0]                way_q, way_d;
  logic [WordW-1:0]               cnt_q, cnt_d;
  logic                           err_q, err_d;
  logic                           fence_pend_q, fence_pend_d;
  logic                           arvalid_q, arvalid_d;
  logic                           rready_q, rready_d;
  logic                           bus_err_q, bus_err_d;
  logic [SETS-1:0][WAYS-1:0]      valid_q, valid_d;
  logic [SETS-1:0][WayW-1:0]      rr_q, rr_d;

  logic            hit_raw;
  logic [31:0]     hit_data;
  logic [WayW-1:0] victim_way;
  logic            tag_we;
  logic            data_we;
  logic            err_now;
  logic            pend_now;
  logic            unused_rid;

  assign unused_rid = ^M_AXI_RID;

  ysyx_23060124__icache_victim #(
    .WAYS (WAYS),
    .WayW (WayW)
  ) u_victim (
    .valid_i (valid_q[set_idx]),
    .rr_i    (rr_q[set_idx]),
    .way_o   (victim_way)
  );

  // Parallel tag compare across the indexed set; at most one way can match.
  always_comb begin
    hit_raw  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_mem[set_idx][w] == tag_in)) begin
        hit_raw  = 1'b1;
        hit_data = hit_data | data_mem[set_idx][w][word_idx];
      end
    end
  end

  assign hit  = hit_raw && (state_q != StFlush);
  assign data = hit ? hit_data : 32'h0;

  // Refill / flush controller next-state logic.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    set_d        = set_q;
    way_d        = way_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fence_pend_d = fence_pend_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    bus_err_d    = 1'b0;
    valid_d      = valid_q;
    rr_d         = rr_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    err_now      = 1'b0;
    pend_now     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fence_i) begin
          state_d = StFlush;
        end else if (!hit_raw) begin
          line_addr_d = (addr >> OffW) << OffW;
          set_d       = set_idx;
          way_d       = victim_way;
          arvalid_d   = 1'b1;
          state_d     = StAr;
        end
      end
      StAr: begin
        if (fence_i) fence_pend_d = 1'b1;
        if (M_AXI_ARREADY) begin
          // Victim goes invalid now so a partial line can never hit.
          valid_d[set_q][way_q] = 1'b0;
          tag_we    = 1'b1;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (fence_i) fence_pend_d = 1'b1;
        if (M_AXI_RVALID) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          err_now = err_q || (M_AXI_RRESP != AxiRespOkay);
          err_d   = err_now;
          if (M_AXI_RLAST) begin
            pend_now              = fence_pend_q || fence_i;
            valid_d[set_q][way_q] = !err_now && !pend_now;
            bus_err_d             = err_now;
            rr_d[set_q]           = (rr_q[set_q] == WayW'(WAYS - 1)) ? '0 : rr_q[set_q] + 1'b1;
            rready_d              = 1'b0;
            fence_pend_d          = 1'b0;
            state_d               = pend_now ? StFlush : StIdle;
          end
        end
      end
      StFlush: begin
        valid_d      = '0;
        rr_d         = '0;
        fence_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control registers with synchronous reset; a reset mid-burst simply drops the burst.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q      <= StIdle;
      line_addr_q  <= '0;
      set_q        <= '0;
      way_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      set_q        <= set_d;
      way_q        <= way_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fence_pend_q <= fence_pend_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      bus_err_q    <= bus_err_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  // Tag and data array writes; no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[set_q][way_q] <= TagW'(line_addr_q >> (OffW + IdxBits));
    if (data_we) data_mem[set_q][way_q][cnt_q] <= M_AXI_RDATA;
  end

  assign M_AXI_ARADDR  = 32'(line_addr_q);
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = 4'h0;
  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = AxiSize4B;
  assign M_AXI_ARBURST = AxiBurstIncr;
  assign M_AXI_RREADY  = rready_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_ysyx_23060124__icache_assoc.sv
// Directed bench for the associative icache: refill, replacement, fence, error and reset cases.
module tb_ysyx_23060124__icache_assoc;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic [31:0] addr;
  logic [31:0] data;
  logic        hit;
  logic        fence_i;
  logic        bus_err;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [3:0]  M_AXI_ARID;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [3:0]  M_AXI_RID;
  logic        M_AXI_RLAST;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_23060124__icache_assoc dut (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .addr          (addr),
    .data          (data),
    .hit           (hit),
    .fence_i       (fence_i),
    .bus_err       (bus_err),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_ARID    (M_AXI_ARID),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .M_AXI_RID     (M_AXI_RID),
    .M_AXI_RLAST   (M_AXI_RLAST)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave memory image: upper half carries the line address, low byte 0x11*(i+1).
  function automatic logic [31:0] beat_word(input logic [31:0] line, input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return {line[15:0], 8'h00, b};
  endfunction

  task automatic probe(input string tag, input logic [31:0] a, input logic exp_hit,
                       input logic [31:0] exp_data);
    @(negedge clk);
    addr = a;
    #1;
    check({tag, "_hit"}, 64'(hit), 64'(exp_hit));
    check({tag, "_data"}, 64'(data), 64'(exp_data));
  endtask

  // Act as the AXI slave for one refill; negative beat numbers disable that injection.
  task automatic serve(input logic [31:0] line, input int ar_wait, input int fence_beat,
                       input int err_beat, input int rst_beat);
    int n;
    n = 0;
    while (M_AXI_ARVALID !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_valid", 64'(M_AXI_ARVALID), 64'd1);
    check("ar_addr", 64'(M_AXI_ARADDR), 64'(line));
    check("ar_attr", 64'({M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}),
          64'({4'h0, 8'h07, 3'b010, 2'b01}));
    for (int i = 0; i < ar_wait; i++) begin
      // Stray beat while no burst is active must be ignored.
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 32'hdead_beef;
      @(negedge clk);
      check("ar_hold", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'({1'b1, line}));
    end
    M_AXI_RVALID  = 1'b0;
    M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    M_AXI_ARREADY = 1'b0;
    check("ar_drop", 64'(M_AXI_ARVALID), 64'd0);
    check("r_ready", 64'(M_AXI_RREADY), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) @(negedge clk);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = beat_word(line, i);
      M_AXI_RLAST  = (i == 7);
      M_AXI_RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
      fence_i      = (i == fence_beat);
      rst_sync     = (i == rst_beat);
      @(negedge clk);
      M_AXI_RVALID = 1'b0;
      M_AXI_RLAST  = 1'b0;
      M_AXI_RRESP  = 2'b00;
      fence_i      = 1'b0;
      if (i == rst_beat) begin
        rst_sync = 1'b0;
        #1;
        check("rst_mid_arvalid", 64'(M_AXI_ARVALID), 64'd0);
        check("rst_mid_rready", 64'(M_AXI_RREADY), 64'd0);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_sync      = 1'b1;
    addr          = 32'h8000_0004;
    fence_i       = 1'b0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RID     = 4'h0;
    M_AXI_RLAST   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    check("rst_rready", 64'(M_AXI_RREADY), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_hit", 64'(hit), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    rst_sync = 1'b0;

    // Cold miss, ARREADY after two cycles.
    serve(32'h8000_0000, 2, -1, -1, -1);
    #1;
    check("cold_hit", 64'(hit), 64'd1);
    check("cold_data", 64'(data), 64'h22);
    check("cold_bus_err", 64'(bus_err), 64'd0);
    probe("cold_w0", 32'h8000_0000, 1'b1, 32'h11);

    // Replacement in set 0: invalid-first, then round-robin.
    probe("s0_b_miss", 32'h8000_0100, 1'b0, 32'h0);
    serve(32'h8000_0100, 0, -1, -1, -1);
    probe("s0_c_miss", 32'h8000_0200, 1'b0, 32'h0);
    serve(32'h8000_0200, 1, -1, -1, -1);
    probe("keep_b", 32'h8000_0104, 1'b1, 32'h0100_0022);
    probe("new_c", 32'h8000_0200, 1'b1, 32'h0200_0011);
    probe("evict_a", 32'h8000_0000, 1'b0, 32'h0);
    serve(32'h8000_0000, 0, -1, -1, -1);
    probe("keep_c", 32'h8000_0200, 1'b1, 32'h0200_0011);
    probe("evict_b", 32'h8000_0100, 1'b0, 32'h0);
    serve(32'h8000_0100, 0, -1, -1, -1);

    // Fence in idle.
    @(negedge clk);
    addr    = 32'h8000_0000;
    fence_i = 1'b1;
    #1;
    check("pre_fence_hit", 64'(hit), 64'd1);
    @(negedge clk);
    fence_i = 1'b0;
    #1;
    check("flush_hit", 64'(hit), 64'd0);
    check("flush_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    @(negedge clk);
    #1;
    check("post_flush_hit", 64'(hit), 64'd0);
    serve(32'h8000_0000, 1, -1, -1, -1);
    probe("fence_refill", 32'h8000_0004, 1'b1, 32'h22);
    probe("flushed_b", 32'h8000_0104, 1'b0, 32'h0);
    serve(32'h8000_0100, 0, -1, -1, -1);

    // Fence during beat 3 of a refill.
    probe("pend_miss", 32'h8000_0044, 1'b0, 32'h0);
    serve(32'h8000_0040, 0, 3, -1, -1);
    #1;
    check("pend_hit", 64'(hit), 64'd0);
    check("pend_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    @(negedge clk);
    #1;
    check("pend_idle_hit", 64'(hit), 64'd0);
    serve(32'h8000_0040, 0, -1, -1, -1);
    #1;
    check("pend_refetch_hit", 64'(hit), 64'd1);
    check("pend_refetch_data", 64'(data), 64'h0040_0022);
    probe("pend_flushed", 32'h8000_0004, 1'b0, 32'h0);
    serve(32'h8000_0000, 0, -1, -1, -1);

    // Error response on beat 5.
    probe("err_miss", 32'h8000_0064, 1'b0, 32'h0);
    serve(32'h8000_0060, 0, -1, 5, -1);
    #1;
    check("err_pulse", 64'(bus_err), 64'd1);
    check("err_line_hit", 64'(hit), 64'd0);
    @(negedge clk);
    #1;
    check("err_pulse_end", 64'(bus_err), 64'd0);
    serve(32'h8000_0060, 0, -1, -1, -1);
    #1;
    check("err_refetch_hit", 64'(hit), 64'd1);
    check("err_refetch_data", 64'(data), 64'h0060_0022);
    check("err_refetch_bus_err", 64'(bus_err), 64'd0);

    // Reset at beat 4.
    probe("rst_miss", 32'h8000_0084, 1'b0, 32'h0);
    serve(32'h8000_0080, 0, -1, -1, 4);
    check("rst_line_hit", 64'(hit), 64'd0);
    serve(32'h8000_0080, 0, -1, -1, -1);
    #1;
    check("rst_refetch_hit", 64'(hit), 64'd1);
    check("rst_refetch_data", 64'(data), 64'h0080_0022);
    probe("rst_cleared", 32'h8000_0064, 1'b0, 32'h0);
    serve(32'h8000_0060, 0, -1, -1, -1);
    #1;
    check("final_hit", 64'(hit), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124__icache_assoc.md
YSYX_23060124__ICACHE_ASSOC -- requirements
Module: ysyx_23060124__icache_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: fetch/AXI address width.
REQ-002 SHALL have parameter WAYS, default 2: associativity; power of two, 1..8.
REQ-003 SHALL have parameter SETS, default 8: set count; power of two, >=1.
REQ-004 SHALL have parameter LINE_WORDS, default 8: 32-bit words per line; power of two, 2..16.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst_sync  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: addr  in  ADDR_WIDTH  fetch address, word-aligned.
REQ-008 SHALL have ports: data  out  32  fetched word, valid when hit=1; otherwise 0.
REQ-009 SHALL have ports: hit  out  1  addr present in a valid way.
REQ-010 SHALL have ports: fence_i  in  1  invalidate-all request, single-cycle pulse.
REQ-011 SHALL have ports: bus_err  out  1  one-cycle pulse on refill error response.
REQ-012 SHALL have ports: M_AXI_ARADDR/ARVALID/ARREADY/ARID/ARLEN/ARSIZE/ARBURST and M_AXI_RDATA/RRESP/RVALID/RREADY/RID/RLAST, AXI4 read channels, widths 32/1/1/4/8/3/2 and 32/2/1/1/4/1; no write channels.

Function
REQ-013 SHALL split addr as tag=[ADDR_WIDTH-1:OFF+IDX], set index=[OFF+IDX-1:OFF], word=[OFF-1:2], with OFF=log2(4*LINE_WORDS), IDX=log2(SETS).
REQ-014 SHALL compute hit and data combinationally in the same cycle as addr, comparing tag against every way of the indexed set; at most one way matches.
REQ-015 SHALL use FSM states IDLE, AR, RDATA, FLUSH.
REQ-016 IDLE, hit=0, no fence pending: latch line-aligned addr and victim way, go to AR next cycle with ARVALID=1.
REQ-017 AR: hold ARVALID and ARADDR stable until ARREADY; on handshake clear victim valid bit, write its tag, go to RDATA.
REQ-018 SHALL drive ARLEN=LINE_WORDS-1, ARSIZE=3'b010, ARBURST=2'b01 (INCR), ARID=0.
REQ-019 RDATA: RREADY=1 continuously; each RVALID beat written to victim way at a word counter starting 0, incremented per beat, wrapping modulo LINE_WORDS.
REQ-020 On the beat with RLAST: victim valid set to 1 if all beats had RRESP=2'b00, else left 0 and bus_err pulsed next cycle; return to IDLE.
REQ-021 Victim selection: lowest-numbered invalid way in the set; if none, per-set round-robin pointer, advanced by one (wrapping at WAYS) on each completed refill of that set.
REQ-022 A hit SHALL NOT change replacement state.
REQ-023 fence_i in IDLE: go to FLUSH; FLUSH clears all valid bits in one cycle, resets all round-robin pointers to 0, returns to IDLE; hit=0 during FLUSH.
REQ-024 fence_i during AR or RDATA: recorded as pending; refill runs to completion but line stays invalid; FLUSH entered after RLAST.
REQ-025 If addr changes during refill, refill completes unchanged; new miss serviced from IDLE afterwards.
REQ-026 Beats with RVALID=1 outside RDATA SHALL be ignored; RID not checked.

Reset
REQ-027 rst_sync=1 SHALL force IDLE, all valid bits 0, pointers 0, ARVALID=0, RREADY=0, bus_err=0, pending fence 0; hit=0, data=0 follow.
REQ-028 Reset mid-burst SHALL abandon the burst; no line validated; data/tag arrays need no reset.

Structure
REQ-029 Shared package SHALL hold FSM state enum, AXI constants (INCR, SIZE_4B, RESP_OKAY) and derived-width functions.
REQ-030 One sub-module ysyx_23060124__icache_victim (per-set invalid-first/round-robin selector) SHALL be instantiated; data storage inline.

Verification
REQ-031 Cold miss at 0x8000_0004, slave returns 0x11..0x88, ARREADY after 2 cycles -> ARADDR=0x8000_0000, ARLEN=7, then hit=1, data=0x22.
REQ-032 Fill both ways of set 0 (0x8000_0000, 0x8000_0100), miss 0x8000_0200 -> way 0 replaced; next set-0 miss replaces way 1.
REQ-033 fence_i in IDLE after fills -> one FLUSH cycle, then hit=0 for 0x8000_0000, new AR issued.
REQ-034 fence_i during beat 3 of refill -> burst completes, hit stays 0, FLUSH follows RLAST, line refetched.
REQ-035 RRESP=2'b10 on beat 5 -> bus_err one-cycle pulse after RLAST, line invalid, refetch issued.
REQ-036 rst_sync asserted at beat 4 -> ARVALID=0, RREADY=0 next cycle, hit=0 for that line after reset.
